// File: rtl/i2c_reg_target_pkg.sv
// Shared definitions for the I2C/SCCB register target.
//   - i2c_state_e  : target FSM encoding
//   - i2c_lines_t  : filtered SCL/SDA pair
//   - DEF_I2C_ADDR : default 7-bit target address
//   - REG_*        : register map indices used by sys_control / colorDetect_top
//   - addr_hit()   : address byte compare (bits [7:1] against the 7-bit address)
package colorDetect_definitions;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2c_state_e;

    typedef struct packed {
        logic scl;
        logic sda;
    } i2c_lines_t;

    localparam logic [6:0] DEF_I2C_ADDR = 7'h50;

    // Register map
    localparam int REG_CTRL          = 0;   // bit0 gaussian_enable override, bit1 override valid
    localparam int CTRL_GAUSS_EN_BIT = 0;
    localparam int CTRL_OVR_VLD_BIT  = 1;
    localparam int REG_THRESH_FIRST  = 1;   // colour hue/sat/val thresholds
    localparam int REG_THRESH_LAST   = 12;
    localparam int REG_SPARE_FIRST   = 13;
    localparam int REG_SPARE_LAST    = 15;

    function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] addr);
        return addr_byte[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus glitch filter for one open-drain bus line.
//   clk    : system clock
//   rstn   : asynchronous active-low reset (output resets to 1 = idle bus)
//   i_raw  : raw pad input
//   o_filt : filtered level; changes only after FILTER_LEN consecutive
//            identical synchronised samples that differ from the current level
module i2c_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_raw,
    output logic o_filt
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Only two levels exist, so every sample differing from o_filt is the
    // same candidate value; counting the run of differing samples suffices.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync   <= 2'b11;
            cnt    <= '0;
            o_filt <= 1'b1;
        end else begin
            sync <= {sync[0], i_raw};
            if (sync[1] == o_filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                o_filt <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C/SCCB target exposing a byte-wide register file to an external host.
// Open-drain only (SDA pulled low or released), no clock stretching.
//   i_sysclk   : system clock
//   db_rstn    : asynchronous active-low reset
//   i_scl      : raw SCL pad input
//   i_sda      : raw SDA pad input
//   o_sda_oe   : 1 = pull SDA low
//   o_regs     : flattened register file, register 0 in the LSBs
//   o_wr_pulse : one-cycle strobe per committed write byte
//   o_wr_idx   : register index written, valid with o_wr_pulse
//   o_busy     : high from START to STOP
// Protocol: write = START, addr+W, pointer, data..., STOP (pointer auto-increments).
//           read  = START, addr+R, data... (from current pointer, auto-increment).
module i2c_reg_target
    import colorDetect_definitions::*;
#(
    parameter logic [6:0]            I2C_ADDR   = DEF_I2C_ADDR,
    parameter int                    NUM_REGS   = 16,   // power of two
    parameter int                    FILTER_LEN = 4,
    parameter logic [NUM_REGS*8-1:0] REG_RESET  = {NUM_REGS{8'h00}}
) (
    input  logic                        i_sysclk,
    input  logic                        db_rstn,
    input  logic                        i_scl,
    input  logic                        i_sda,
    output logic                        o_sda_oe,
    output logic [NUM_REGS*8-1:0]       o_regs,
    output logic                        o_wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0] o_wr_idx,
    output logic                        o_busy
);

    localparam int IDX_W = $clog2(NUM_REGS);

    // ------------------------------------------------------------------
    // Line conditioning: index 0 = SCL, index 1 = SDA
    // ------------------------------------------------------------------
    logic [1:0] raw_lines;
    logic [1:0] filt_lines;

    assign raw_lines = {i_sda, i_scl};

    for (genvar g = 0; g < 2; g++) begin : g_line
        i2c_line_filter #(
            .FILTER_LEN(FILTER_LEN)
        ) u_filt (
            .clk   (i_sysclk),
            .rstn  (db_rstn),
            .i_raw (raw_lines[g]),
            .o_filt(filt_lines[g])
        );
    end

    i2c_lines_t cur;
    i2c_lines_t prev;

    assign cur.scl = filt_lines[0];
    assign cur.sda = filt_lines[1];

    logic scl_rise;
    logic scl_fall;
    logic start_ev;
    logic stop_ev;

    assign scl_rise = cur.scl & ~prev.scl;
    assign scl_fall = ~cur.scl & prev.scl;
    // SCL must be high on both samples so an SDA change coincident with an
    // SCL edge is never taken as START/STOP.
    assign start_ev = cur.scl & prev.scl & prev.sda & ~cur.sda;
    assign stop_ev  = cur.scl & prev.scl & ~prev.sda & cur.sda;

    // ------------------------------------------------------------------
    // State and datapath
    // ------------------------------------------------------------------
    i2c_state_e state;
    i2c_state_e state_nxt;

    logic [NUM_REGS-1:0][7:0] regs;
    logic [7:0]               sh;
    logic [7:0]               sh_nxt;
    logic [3:0]               bit_cnt;
    logic [3:0]               cnt_nxt;
    logic [IDX_W-1:0]         ptr;
    logic [IDX_W-1:0]         ptr_nxt;
    logic                     rw;
    logic                     rw_nxt;
    logic                     sda_oe;
    logic                     oe_nxt;
    logic                     wr_en;
    logic                     wr_pulse;
    logic [IDX_W-1:0]         wr_idx;
    logic                     busy;
    logic [7:0]               rx_byte;
    logic [7:0]               rd_byte;

    // Byte as it stands once the bit on the current rise is shifted in.
    assign rx_byte = {sh[6:0], cur.sda};
    assign rd_byte = regs[ptr];

    // State register
    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. bit_cnt counts rises within a byte; the value 8
    // marks "byte complete, ACK slot opens on the next fall".
    always_comb begin
        state_nxt = state;
        if (start_ev) begin
            state_nxt = ADDR;
        end else if (stop_ev) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && bit_cnt == 4'd7 && !addr_hit(rx_byte, I2C_ADDR))
                        state_nxt = IGNORE;
                    else if (scl_fall && bit_cnt == 4'd8)
                        state_nxt = ADDR_ACK;
                end
                ADDR_ACK:  if (scl_fall) state_nxt = rw ? RDATA : PTR;
                PTR:       if (scl_fall && bit_cnt == 4'd8) state_nxt = PTR_ACK;
                PTR_ACK:   if (scl_fall) state_nxt = WDATA;
                WDATA:     if (scl_fall && bit_cnt == 4'd8) state_nxt = WDATA_ACK;
                WDATA_ACK: if (scl_fall) state_nxt = WDATA;
                RDATA:     if (scl_fall && bit_cnt == 4'd8) state_nxt = RDATA_ACK;
                RDATA_ACK: begin
                    if (scl_rise && cur.sda)
                        state_nxt = IGNORE;   // master NACK ends the read
                    else if (scl_fall)
                        state_nxt = RDATA;
                end
                default: ;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        oe_nxt  = sda_oe;
        cnt_nxt = bit_cnt;
        sh_nxt  = sh;
        ptr_nxt = ptr;
        rw_nxt  = rw;
        wr_en   = 1'b0;
        busy    = (state != IDLE);
        if (start_ev || stop_ev) begin
            oe_nxt  = 1'b0;
            cnt_nxt = '0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        sh_nxt  = rx_byte;
                        cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            case (state)
                                ADDR:    rw_nxt  = cur.sda;
                                PTR:     ptr_nxt = rx_byte[IDX_W-1:0];
                                default: begin
                                    wr_en   = 1'b1;
                                    ptr_nxt = ptr + IDX_W'(1);
                                end
                            endcase
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        oe_nxt  = 1'b1;        // ACK
                        cnt_nxt = '0;
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        oe_nxt  = 1'b0;
                        cnt_nxt = '0;
                        if (state == ADDR_ACK && rw) begin
                            // Pointer post-increments as each read byte is fetched.
                            sh_nxt  = rd_byte;
                            oe_nxt  = ~rd_byte[7];
                            ptr_nxt = ptr + IDX_W'(1);
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_nxt  = 1'b0;    // release for master ACK
                            cnt_nxt = '0;
                        end else begin
                            // Rotate so sh[7] always holds the bit on the bus.
                            sh_nxt = {sh[6:0], sh[7]};
                            oe_nxt = ~sh[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall) begin
                        sh_nxt  = rd_byte;
                        oe_nxt  = ~rd_byte[7];
                        cnt_nxt = '0;
                        ptr_nxt = ptr + IDX_W'(1);
                    end
                end
                default: oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            prev     <= '1;
            sda_oe   <= 1'b0;
            bit_cnt  <= '0;
            sh       <= '0;
            ptr      <= '0;
            rw       <= 1'b0;
            regs     <= REG_RESET;
            wr_pulse <= 1'b0;
            wr_idx   <= '0;
        end else begin
            prev     <= cur;
            sda_oe   <= oe_nxt;
            bit_cnt  <= cnt_nxt;
            sh       <= sh_nxt;
            ptr      <= ptr_nxt;
            rw       <= rw_nxt;
            wr_pulse <= wr_en;
            if (wr_en) begin
                regs[ptr] <= rx_byte;
                wr_idx    <= ptr;
            end
        end
    end

    assign o_sda_oe   = sda_oe;
    assign o_regs     = regs;
    assign o_wr_pulse = wr_pulse;
    assign o_wr_idx   = wr_idx;
    assign o_busy     = busy;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target acting as a bus initiator.
module tb_i2c_reg_target;

    localparam int NR = 16;
    localparam int Q  = 12;   // quarter SCL period in system clocks
    localparam logic [NR*8-1:0] RST = 128'h0F0E0D0C0B0A09080706050403020100;

    logic i_sysclk = 1'b0;
    logic db_rstn  = 1'b0;
    logic scl_m    = 1'b1;
    logic sda_m    = 1'b1;
    logic i_scl;
    logic i_sda;
    logic o_sda_oe;
    logic o_wr_pulse;
    logic o_busy;
    logic [NR*8-1:0] o_regs;
    logic [3:0] o_wr_idx;

    int checks   = 0;
    int failures = 0;
    int oe_cnt   = 0;
    logic [3:0] wr_log[$];
    logic [NR*8-1:0] exp_regs = RST;

    always #4 i_sysclk = ~i_sysclk;

    assign i_scl = scl_m;
    assign i_sda = sda_m & ~o_sda_oe;

    i2c_reg_target #(
        .I2C_ADDR  (7'h50),
        .NUM_REGS  (NR),
        .FILTER_LEN(4),
        .REG_RESET (RST)
    ) dut (
        .i_sysclk  (i_sysclk),
        .db_rstn   (db_rstn),
        .i_scl     (i_scl),
        .i_sda     (i_sda),
        .o_sda_oe  (o_sda_oe),
        .o_regs    (o_regs),
        .o_wr_pulse(o_wr_pulse),
        .o_wr_idx  (o_wr_idx),
        .o_busy    (o_busy)
    );

    always @(negedge i_sysclk) begin
        if (o_wr_pulse) wr_log.push_back(o_wr_idx);
        if (o_sda_oe) oe_cnt = oe_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_sysclk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic bus_bit(input logic b, input bit glitch, output logic smp);
        sda_m = b; tick(Q);
        scl_m = 1'b1; tick(Q);
        smp = i_sda;
        if (glitch) begin
            tick(3); scl_m = 1'b0; tick(2); scl_m = 1'b1; tick(Q - 5);
        end else begin
            tick(Q);
        end
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
        logic smp;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], (i == gbit), smp);
        bus_bit(1'b1, 1'b0, smp);
        ack = (smp === 1'b0);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic smp;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 1'b0, smp);
            d[i] = smp;
        end
        bus_bit(nack, 1'b0, smp);
    endtask

    function automatic logic [7:0] log_pair(input int w0);
        if (wr_log.size() >= w0 + 2) return {wr_log[w0], wr_log[w0+1]};
        return 8'hxx;
    endfunction

    task automatic test_reset();
        tick(5);
        if (o_sda_oe !== 1'b0) begin failures++; $display("FAIL rst_oe got=%b exp=0", o_sda_oe); end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
        checks++;
        if (o_wr_pulse !== 1'b0) begin failures++; $display("FAIL rst_pulse got=%b exp=0", o_wr_pulse); end
        checks++;
        if (o_wr_idx !== 4'd0) begin failures++; $display("FAIL rst_idx got=%0d exp=0", o_wr_idx); end
        checks++;
        if (o_regs !== RST) begin failures++; $display("FAIL rst_regs got=%h exp=%h", o_regs, RST); end
        checks++;
        db_rstn = 1'b1;
        tick(20);
        if (o_busy !== 1'b0 || o_sda_oe !== 1'b0) begin
            failures++; $display("FAIL post_rst_idle got busy=%b oe=%b exp=0/0", o_busy, o_sda_oe);
        end
        checks++;
    endtask

    task automatic test_write();
        logic [3:0] a;
        int w0 = wr_log.size();
        bus_start();
        write_byte(8'hA0, -1, a[3]);
        write_byte(8'h03, -1, a[2]);
        write_byte(8'hA5, -1, a[1]);
        write_byte(8'h5A, -1, a[0]);
        if (a !== 4'b1111) begin failures++; $display("FAIL wr_acks got=%b exp=1111", a); end
        checks++;
        if (o_busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", o_busy); end
        checks++;
        bus_stop();
        tick(Q);
        if (o_busy !== 1'b0) begin failures++; $display("FAIL wr_busy_stop got=%b exp=0", o_busy); end
        checks++;
        exp_regs[3*8 +: 8] = 8'hA5;
        exp_regs[4*8 +: 8] = 8'h5A;
        if (o_regs !== exp_regs) begin failures++; $display("FAIL wr_regs got=%h exp=%h", o_regs, exp_regs); end
        checks++;
        if (wr_log.size() - w0 !== 2) begin
            failures++; $display("FAIL wr_pulses got=%0d exp=2", wr_log.size() - w0);
        end
        checks++;
        if (log_pair(w0) !== 8'h34) begin failures++; $display("FAIL wr_idx got=%h exp=34", log_pair(w0)); end
        checks++;
    endtask

    task automatic test_read();
        logic [2:0] a;
        logic [7:0] d0, d1, d2;
        int w0 = wr_log.size();
        bus_start();
        write_byte(8'hA0, -1, a[2]);
        write_byte(8'h03, -1, a[1]);
        bus_start();
        write_byte(8'hA1, -1, a[0]);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        if (a !== 3'b111) begin failures++; $display("FAIL rd_acks got=%b exp=111", a); end
        checks++;
        if (d0 !== 8'hA5) begin failures++; $display("FAIL rd_byte0 got=%h exp=a5", d0); end
        checks++;
        if (d1 !== 8'h5A) begin failures++; $display("FAIL rd_byte1 got=%h exp=5a", d1); end
        checks++;
        if (o_sda_oe !== 1'b0) begin failures++; $display("FAIL rd_release got=%b exp=0", o_sda_oe); end
        checks++;
        bus_stop();
        // Pointer should now be 5: read without pointer write
        bus_start();
        write_byte(8'hA1, -1, a[0]);
        read_byte(1'b1, d2);
        bus_stop();
        if (d2 !== 8'h05) begin failures++; $display("FAIL rd_ptr5 got=%h exp=05", d2); end
        checks++;
        if (wr_log.size() !== w0) begin failures++; $display("FAIL rd_no_write got=%0d exp=%0d", wr_log.size(), w0); end
        checks++;
    endtask

    task automatic test_mismatch();
        logic [2:0] a;
        int w0 = wr_log.size();
        int oe0 = oe_cnt;
        bus_start();
        write_byte(8'hB0, -1, a[2]);
        write_byte(8'h00, -1, a[1]);
        write_byte(8'hFF, -1, a[0]);
        bus_stop();
        tick(Q);
        if (a !== 3'b000) begin failures++; $display("FAIL mm_acks got=%b exp=000", a); end
        checks++;
        if (oe_cnt !== oe0) begin failures++; $display("FAIL mm_oe got=%0d exp=%0d", oe_cnt, oe0); end
        checks++;
        if (o_regs !== exp_regs) begin failures++; $display("FAIL mm_regs got=%h exp=%h", o_regs, exp_regs); end
        checks++;
        if (wr_log.size() !== w0) begin failures++; $display("FAIL mm_pulse got=%0d exp=%0d", wr_log.size(), w0); end
        checks++;
    endtask

    task automatic test_wrap();
        logic [3:0] a;
        int w0 = wr_log.size();
        bus_start();
        write_byte(8'hA0, -1, a[3]);
        write_byte(8'h0F, -1, a[2]);
        write_byte(8'h11, -1, a[1]);
        write_byte(8'h22, -1, a[0]);
        bus_stop();
        tick(Q);
        exp_regs[15*8 +: 8] = 8'h11;
        exp_regs[0 +: 8]    = 8'h22;
        if (a !== 4'b1111) begin failures++; $display("FAIL wrap_acks got=%b exp=1111", a); end
        checks++;
        if (o_regs !== exp_regs) begin failures++; $display("FAIL wrap_regs got=%h exp=%h", o_regs, exp_regs); end
        checks++;
        if (log_pair(w0) !== 8'hF0) begin failures++; $display("FAIL wrap_idx got=%h exp=f0", log_pair(w0)); end
        checks++;
    endtask

    task automatic test_glitch();
        logic [2:0] a;
        int w0 = wr_log.size();
        bus_start();
        write_byte(8'hA0, -1, a[2]);
        write_byte(8'h07, -1, a[1]);
        write_byte(8'h3C, 3, a[0]);
        bus_stop();
        tick(Q);
        exp_regs[7*8 +: 8] = 8'h3C;
        if (a !== 3'b111) begin failures++; $display("FAIL gl_acks got=%b exp=111", a); end
        checks++;
        if (o_regs !== exp_regs) begin failures++; $display("FAIL gl_regs got=%h exp=%h", o_regs, exp_regs); end
        checks++;
        if (wr_log.size() - w0 !== 1) begin
            failures++; $display("FAIL gl_pulses got=%0d exp=1", wr_log.size() - w0);
        end else if (wr_log[w0] !== 4'd7) begin
            failures++; $display("FAIL gl_idx got=%0d exp=7", wr_log[w0]);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        logic [2:0] a;
        logic smp;
        logic [7:0] b = 8'h99;
        int w0;
        bus_start();
        write_byte(8'hA0, -1, a[2]);
        write_byte(8'h02, -1, a[1]);
        for (int i = 7; i >= 4; i--) bus_bit(b[i], 1'b0, smp);
        sda_m = b[3];
        tick(3);
        if (o_busy !== 1'b1) begin failures++; $display("FAIL mid_busy_pre got=%b exp=1", o_busy); end
        checks++;
        db_rstn = 1'b0;
        #1;
        if (o_sda_oe !== 1'b0 || o_busy !== 1'b0) begin
            failures++; $display("FAIL mid_rst_ctl got oe=%b busy=%b exp=0/0", o_sda_oe, o_busy);
        end
        checks++;
        if (o_regs !== RST) begin failures++; $display("FAIL mid_rst_regs got=%h exp=%h", o_regs, RST); end
        checks++;
        exp_regs = RST;
        tick(5);
        sda_m = 1'b1;
        db_rstn = 1'b1;
        tick(Q);
        bus_stop();
        w0 = wr_log.size();
        bus_start();
        write_byte(8'hA0, -1, a[2]);
        write_byte(8'h02, -1, a[1]);
        write_byte(8'h77, -1, a[0]);
        bus_stop();
        tick(Q);
        exp_regs[2*8 +: 8] = 8'h77;
        if (a !== 3'b111) begin failures++; $display("FAIL post_acks got=%b exp=111", a); end
        checks++;
        if (o_regs !== exp_regs) begin failures++; $display("FAIL post_regs got=%h exp=%h", o_regs, exp_regs); end
        checks++;
        if (wr_log.size() - w0 !== 1) begin
            failures++; $display("FAIL post_pulses got=%0d exp=1", wr_log.size() - w0);
        end else if (wr_log[w0] !== 4'd2) begin
            failures++; $display("FAIL post_idx got=%0d exp=2", wr_log[w0]);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_wrap();
        test_glitch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached without completion");
        $fatal(1);
    end

endmodule

// File: doc/i2c_reg_target.md
Name: i2c_reg_target

Overview:
- I2C/SCCB target (responder) on i_sysclk. It is the other end of the bus the camera block drives as initiator.
- Exposes a byte-wide control register file to an external host: colour thresholds, filter enable and mode bits.
- Register contents feed sys_control and colorDetect_top in place of hard-wired constants.
- Open-drain only: pulls SDA low, never drives high. No clock stretching.

Parameters:
- I2C_ADDR, 7'h50, 7-bit target address.
- NUM_REGS, 16, number of 8-bit registers. Must be a power of two.
- FILTER_LEN, 4, consecutive equal samples required before a filtered line changes.
- REG_RESET, {NUM_REGS{8'h00}}, flattened reset contents. Register 0 occupies the LSBs.

Ports:
- i_sysclk  in  1  125 MHz system clock
- db_rstn  in  1  reset, asynchronous, active-low
- i_scl  in  1  raw SCL pad input
- i_sda  in  1  raw SDA pad input
- o_sda_oe  out  1  1 = pull SDA low; top-level ties pad to (o_sda_oe ? 0 : z)
- o_regs  out  NUM_REGS*8  register file contents
- o_wr_pulse  out  1  one-cycle strobe for each committed write byte
- o_wr_idx  out  log2(NUM_REGS)  index of the register written; valid with o_wr_pulse
- o_busy  out  1  high from START to STOP

Behaviour:
- Reset values:
  - o_sda_oe=0, o_busy=0, o_wr_pulse=0, o_wr_idx=0.
  - o_regs=REG_RESET, pointer=0, state IDLE.
  - Filtered lines reset to 1.
- Input conditioning:
  - 2-FF synchroniser on each line.
  - Filter: output takes a new value only after FILTER_LEN consecutive identical synchronised samples.
  - Edge and event detection runs on filtered values, so SCL/SDA have an effective latency of 2+FILTER_LEN cycles.
- Events (each valid in any state):
  - START: filtered SDA falls while SCL is high. Go to ADDR, clear bit counter, set o_busy=1, release SDA.
  - STOP: filtered SDA rises while SCL is high. Go to IDLE, set o_busy=0, release SDA.
  - A repeated START is a START. The pointer is preserved.
- Bus timing:
  - Target samples SDA on filtered SCL rising edges.
  - Target changes o_sda_oe on the cycle after a filtered SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first. On the 8th rise, compare bits[7:1] with I2C_ADDR.
    - Match: on the next fall assert o_sda_oe and go to ADDR_ACK, capturing the R/W bit.
    - Mismatch: go to IGNORE without ACK.
  - ADDR_ACK: hold ACK through the 9th rise; release at the 9th fall.
    - W: go to PTR.
    - R: load reg[pointer], drive its MSB (o_sda_oe = ~bit), go to RDATA.
  - PTR: shift 8 bits; pointer = byte mod NUM_REGS. ACK as above, then go to WDATA.
  - WDATA: shift 8 bits.
    - At the 8th rise: write reg[pointer], pulse o_wr_pulse one cycle with o_wr_idx = pointer, then pointer++ (wraps at NUM_REGS).
    - ACK as above, then go to WDATA again.
  - RDATA: drive bits on falls. Release SDA on the fall after bit 0. Go to RDATA_ACK.
  - RDATA_ACK: sample master ACK at the 9th rise.
    - ACK (0): pointer++, load next byte at the 9th fall, drive its MSB, go to RDATA.
    - NACK (1): go to IGNORE.
  - IGNORE: o_sda_oe=0; wait for START or STOP.
- Boundary conditions:
  - Data bytes after a pointer write always commit; there is no write-protect.
  - A STOP mid-byte discards the partial byte and performs no write.
  - A read without a preceding pointer write uses the current pointer.
  - Pointer wrap: NUM_REGS-1 + 1 = 0.
  - A reset asserted mid-transaction returns everything to reset values immediately. The bus may hang until the initiator issues a STOP.
- Register map (system use):
  - 0: bit0 gaussian_enable override, bit1 override valid.
  - 1..12: colour hue/sat/val thresholds.
  - 13..15: spare.

Decomposition:
- Shared package colorDetect_definitions holds:
  - state encoding (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE);
  - default I2C_ADDR;
  - register index constants.
- Sub-module i2c_line_filter: synchroniser plus glitch filter, parameter FILTER_LEN, ports clk/rstn/i_raw/o_filt. Instantiated twice.

Test Plan:
- Write: START, 0xA0, ptr 0x03, data 0xA5, 0x5A, STOP → ACK on all four bytes; reg3=0xA5, reg4=0x5A; o_wr_pulse twice with idx 3 then 4; o_busy low after STOP.
- Read: write ptr 0x03, repeated START, 0xA1, read two bytes (ACK then NACK) → bus returns 0xA5, 0x5A; SDA released after NACK; pointer=5.
- Address mismatch: START, 0xB0, ptr 0x00, data 0xFF → SDA never pulled low; o_regs unchanged; no o_wr_pulse.
- Wrap: ptr 0x0F, data 0x11, 0x22 → reg15=0x11, reg0=0x22; o_wr_idx 15 then 0.
- Glitch: 2-cycle low pulse on SCL mid-byte (FILTER_LEN=4) → no extra bit shifted; subsequent write lands correctly.
- Reset: assert db_rstn low during WDATA bit 4 → o_sda_oe=0, o_busy=0, o_regs=REG_RESET in the same cycle; next full transaction succeeds.
